muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
- REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
- REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
- REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
- REQ-004 SHALL have port start, input, 1, EX-stage valid RV32M instruction; held high by the pipeline while stalled.
- REQ-005 SHALL have port funct3, input, 3, operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- REQ-006 SHALL have port rs1_data, input, 32, multiplicand or dividend.
- REQ-007 SHALL have port rs2_data, input, 32, multiplier or divisor.
- REQ-008 SHALL have port flush, input, 1, kills any in-flight operation.
- REQ-009 SHALL have port result, output, 32, registered result, valid while done=1.
- REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
- REQ-011 SHALL have port busy, output, 1, high in CALC and DONE.
- REQ-012 SHALL have port stall, output, 1, combinational pipeline hold request.

Function
- REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
- REQ-014 In IDLE with start=1 and flush=0: SHALL latch funct3 and operands, clear the 5-bit iteration counter, and go to CALC; exception: div/rem special cases (REQ-019, REQ-020) go directly to DONE.
- REQ-015 In CALC: SHALL perform one iteration per cycle, 32 iterations (counter 0..31); after iteration 31, go to DONE.
- REQ-016 Multiply: SHALL use shift-add on operand magnitudes forming a 64-bit product, then negate if operand signs differ.
  - MUL, MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU: both unsigned.
  - MUL returns product[31:0]; the others return product[63:32].
- REQ-017 Divide: SHALL use restoring division on magnitudes (signed ops) or raw values (unsigned ops).
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
- REQ-018 DONE: SHALL assert done=1 with result valid for exactly one cycle, then return to IDLE; start during DONE SHALL NOT launch a new operation.
- REQ-019 Divisor=0: quotient SHALL be 0xFFFFFFFF and remainder SHALL be rs1; done at T+1.
- REQ-020 DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient SHALL be 0x80000000 and remainder 0; done at T+1.
- REQ-021 Latency: start accepted at edge T SHALL yield done=1 during cycle T+33; T+1 for REQ-019/REQ-020.
- REQ-022 stall SHALL equal (state==IDLE & start & ~flush) | (state==CALC); stall SHALL be 0 in DONE so the pipeline advances while sampling result.
- REQ-023 flush=1 in any state SHALL force IDLE on the next edge with done=0; flush has priority over start.
- REQ-024 A new start in the IDLE cycle immediately after DONE SHALL be accepted (back-to-back M-ops).
- REQ-025 result SHALL hold its last value outside DONE.

Reset
- REQ-026 rst=1 SHALL, at the next edge, force IDLE, counter=0, result=0, done=0, busy=0; it overrides start, flush, and any operation in progress.
- REQ-027 During rst=1, stall SHALL be 0.

Verification
- REQ-028 MUL 7 x 0xFFFFFFFD (-3), start at T -> stall=1 during T..T+32; done=1 and result=0xFFFFFFEB at T+33.
- REQ-029 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- REQ-030 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- REQ-031 DIVU 13/0 -> 0xFFFFFFFF; REMU 13/0 -> 13; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; each with done at T+1.
- REQ-032 Flush and reset:
  - flush at T+10 of a MUL -> no done pulse; busy=0 at T+11; a new start at T+11 completes normally.
  - rst at T+5 -> all outputs 0 next cycle.
- REQ-033 Two back-to-back MULs with start held high -> two done pulses 34 cycles apart, correct results, no lost or duplicated op.

Source files
------------

// File: rtl/muldiv_seq.sv
`timescale 1ns/1ps
// muldiv_seq -- iterative RV32M multiply/divide unit for the EX stage.
//
// Multiplies use a 32-step shift-add on operand magnitudes. Divides use a
// 32-step restoring divider. The result sign is fixed up on the last step.
// Divide-by-zero and signed overflow skip the iterations and finish in one cycle.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     valid M-op in EX (held high while the pipeline is stalled)
//   funct3    000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//             100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs1_data  multiplicand / dividend
//   rs2_data  multiplier / divisor
//   flush     abandon any in-flight operation
//   result    registered result, valid while done=1, held otherwise
//   done      one-cycle completion pulse
//   busy      high in CALC and DONE
//   stall     combinational pipeline hold request
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy,
    output logic            stall
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [4:0]      r_count;
    logic [2:0]      r_op;
    logic            r_neg;
    logic [XLEN-1:0] r_opnd;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;

    logic            w_isDiv;
    logic            w_signA;
    logic            w_signB;
    logic            w_negA;
    logic            w_negB;
    logic [XLEN-1:0] w_magA;
    logic [XLEN-1:0] w_magB;
    logic            w_divZero;
    logic            w_divOvf;
    logic            w_special;
    logic [XLEN-1:0] w_specialRes;

    logic [XLEN:0]     w_addSel;
    logic [XLEN:0]     w_trial;
    logic [XLEN-1:0]   w_hiNext;
    logic [XLEN-1:0]   w_loNext;
    logic [2*XLEN-1:0] w_prodFinal;
    logic [XLEN-1:0]   w_quoFinal;
    logic [XLEN-1:0]   w_remFinal;
    logic [XLEN-1:0]   w_final;

    // Operand decode at launch: which operands are signed, their magnitudes,
    // and whether this is one of the divide corner cases that skips iterating.
    always_comb begin
        w_isDiv      = funct3[2];
        w_signA      = w_isDiv ? ~funct3[0] : (funct3[1:0] != 2'b11);
        w_signB      = w_isDiv ? ~funct3[0] : ~funct3[1];
        w_negA       = w_signA & rs1_data[XLEN-1];
        w_negB       = w_signB & rs2_data[XLEN-1];
        w_magA       = w_negA ? -rs1_data : rs1_data;
        w_magB       = w_negB ? -rs2_data : rs2_data;
        w_divZero    = w_isDiv & (rs2_data == '0);
        w_divOvf     = w_isDiv & ~funct3[0]
                     & (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                     & (rs2_data == {XLEN{1'b1}});
        w_special    = w_divZero | w_divOvf;
        w_specialRes = '0;
        if (w_divZero) begin
            w_specialRes = funct3[1] ? rs1_data : {XLEN{1'b1}};
        end else if (!funct3[1]) begin
            w_specialRes = {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One iteration step. {r_hi, r_lo} is the running product for multiplies
    // (multiplier consumed from the bottom of r_lo) and {remainder, dividend
    // shifting into quotient} for divides. The restoring compare fits in
    // XLEN+1 bits because the partial remainder is always below the divisor.
    always_comb begin
        w_addSel = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_opnd}) : {1'b0, r_hi};
        w_trial  = {r_hi, r_lo[XLEN-1]} - {1'b0, r_opnd};
        if (!r_op[2]) begin
            w_hiNext = w_addSel[XLEN:1];
            w_loNext = {w_addSel[0], r_lo[XLEN-1:1]};
        end else if (!w_trial[XLEN]) begin
            w_hiNext = w_trial[XLEN-1:0];
            w_loNext = {r_lo[XLEN-2:0], 1'b1};
        end else begin
            w_hiNext = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
            w_loNext = {r_lo[XLEN-2:0], 1'b0};
        end
        w_prodFinal = r_neg ? -{w_hiNext, w_loNext} : {w_hiNext, w_loNext};
        w_quoFinal  = r_neg ? -w_loNext : w_loNext;
        w_remFinal  = r_neg ? -w_hiNext : w_hiNext;
        case (r_op)
            3'b000:         w_final = w_prodFinal[XLEN-1:0];
            3'b100, 3'b101: w_final = w_quoFinal;
            3'b110, 3'b111: w_final = w_remFinal;
            default:        w_final = w_prodFinal[2*XLEN-1:XLEN];
        endcase
    end

    // Next-state logic; flush beats everything, including a fresh start.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: if (start) w_stateNext = w_special ? S_DONE : S_CALC;
            S_CALC: if (r_count == 5'd31) w_stateNext = S_DONE;
            S_DONE: w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
        if (flush) begin
            w_stateNext = S_IDLE;
        end
    end

    // Status outputs decode straight from the state; stall drops in DONE so
    // the pipeline advances on the cycle it samples the result.
    always_comb begin
        done  = (r_state == S_DONE);
        busy  = (r_state == S_CALC) | (r_state == S_DONE);
        stall = ~rst & (((r_state == S_IDLE) & start & ~flush) | (r_state == S_CALC));
    end

    // State register and datapath. result only changes when entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_op    <= '0;
            r_neg   <= 1'b0;
            r_opnd  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            result  <= '0;
        end else begin
            r_state <= w_stateNext;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_op    <= funct3;
                        r_count <= '0;
                        r_hi    <= '0;
                        r_neg   <= (w_isDiv && funct3[1]) ? w_negA : (w_negA ^ w_negB);
                        r_opnd  <= w_isDiv ? w_magB : w_magA;
                        r_lo    <= w_isDiv ? w_magA : w_magB;
                        if (w_special) begin
                            result <= w_specialRes;
                        end
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        r_hi    <= w_hiNext;
                        r_lo    <= w_loNext;
                        r_count <= r_count + 5'd1;
                        if (r_count == 5'd31) begin
                            result <= w_final;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
`timescale 1ns/1ps
// Self-checking bench for muldiv_seq: directed corner cases, back-to-back,
// flush and reset sequences, then random operations against a plain
// arithmetic reference model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        stall;

    int nChecks = 0;
    int nFails  = 0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1),
        .rs2_data (rs2),
        .flush    (flush),
        .result   (result),
        .done     (done),
        .busy     (busy),
        .stall    (stall)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Hard stop in case a sequence somehow never returns.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // RISC-V M-extension semantics computed with native arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int     sa;
        int     sb;
        longint la;
        longint lb;
        longint ua;
        longint ub;
        longint p;
        sa = a;
        sb = b;
        la = sa;
        lb = sb;
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'd0: begin p = la * lb; return p[31:0]; end
            3'd1: begin p = la * lb; return p[63:32]; end
            3'd2: begin p = la * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return sa / sb;
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return sa % sb;
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Divide corner cases complete one cycle after acceptance.
    function automatic int expLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
        return 33;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present an operation for the cycle following the next rising edge.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        start  = 1'b1;
        flush  = 1'b0;
        funct3 = f;
        rs1    = a;
        rs2    = b;
    endtask

    // Called at the negedge of the accept cycle; drops start after the edge,
    // waits for done, then checks latency, result, and the cycle after done.
    task automatic waitDone(input string tag, input logic [31:0] exp, input int expLat, input bit checkStall);
        int lat     = 0;
        bit stallOk = 1'b1;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
            @(negedge clk);
            if (done === 1'b1) lat = c;
            else if (stall !== 1'b1) stallOk = 1'b0;
        end
        checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
        if (checkStall) checkOutput({tag, ".stallCalc"}, {31'b0, stallOk}, 32'd1);
        if (lat != 0) begin
            checkOutput({tag, ".result"}, result, exp);
            checkOutput({tag, ".stallDone"}, {31'b0, stall}, 32'd0);
            checkOutput({tag, ".busyDone"}, {31'b0, busy}, 32'd1);
            @(negedge clk);
            checkOutput({tag, ".donePulse"}, {31'b0, done}, 32'd0);
            checkOutput({tag, ".hold"}, result, exp);
        end
    endtask

    task automatic runOp(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit checkStall);
        applyStimulus(f, a, b);
        @(negedge clk);
        checkOutput({tag, ".stallT"}, {31'b0, stall}, 32'd1);
        waitDone(tag, refModel(f, a, b), expLatency(f, a, b), checkStall);
    endtask

    initial begin
        int          lat;
        int          gap;
        int          extra;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        // Reset with start held high: outputs cleared and stall suppressed.
        rst    = 1'b1;
        start  = 1'b1;
        flush  = 1'b0;
        funct3 = 3'd0;
        rs1    = 32'd5;
        rs2    = 32'd6;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.stall", {31'b0, stall}, 32'd0);
        checkOutput("reset.done", {31'b0, done}, 32'd0);
        checkOutput("reset.busy", {31'b0, busy}, 32'd0);
        checkOutput("reset.result", result, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        checkOutput("idle.busy", {31'b0, busy}, 32'd0);
        checkOutput("idle.stall", {31'b0, stall}, 32'd0);

        // Directed operations from the requirement examples.
        runOp("mul7xm3", 3'd0, 32'd7, 32'hFFFFFFFD, 1'b1);
        checkOutput("mul7xm3.value", result, 32'hFFFFFFEB);
        runOp("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        checkOutput("mulhu.value", result, 32'hFFFFFFFE);
        runOp("mulh", 3'd1, 32'h80000000, 32'h80000000, 1'b0);
        checkOutput("mulh.value", result, 32'h40000000);
        runOp("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
        checkOutput("mulhsu.value", result, 32'hFFFFFFFF);
        runOp("div", 3'd4, 32'hFFFFFFF9, 32'd2, 1'b1);
        checkOutput("div.value", result, 32'hFFFFFFFD);
        runOp("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 1'b0);
        checkOutput("rem.value", result, 32'hFFFFFFFF);
        runOp("divu", 3'd5, 32'd100, 32'd7, 1'b0);
        checkOutput("divu.value", result, 32'd14);
        runOp("remu", 3'd7, 32'd100, 32'd7, 1'b0);
        checkOutput("remu.value", result, 32'd2);
        runOp("divuZero", 3'd5, 32'd13, 32'd0, 1'b0);
        checkOutput("divuZero.value", result, 32'hFFFFFFFF);
        runOp("remuZero", 3'd7, 32'd13, 32'd0, 1'b0);
        checkOutput("remuZero.value", result, 32'd13);
        runOp("divOvf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        checkOutput("divOvf.value", result, 32'h80000000);
        runOp("remOvf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        checkOutput("remOvf.value", result, 32'd0);

        // Back-to-back MULs with start held high throughout.
        applyStimulus(3'd0, 32'd1234, 32'd5678);
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) lat = c;
        end
        checkOutput("b2b.first.latency", 32'(lat), 32'd33);
        checkOutput("b2b.first.result", result, 32'd7006652);
        rs1 = 32'hFFFFFF00;
        rs2 = 32'd3;
        gap = 0;
        for (int c = 1; c <= 40 && gap == 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) gap = c;
        end
        checkOutput("b2b.gap", 32'(gap), 32'd34);
        checkOutput("b2b.second.result", result, 32'hFFFFFD00);
        start = 1'b0;
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checkOutput("b2b.noExtra", 32'(extra), 32'd0);

        // Flush in cycle T+10 of a MUL, then a new op in T+11.
        applyStimulus(3'd0, 32'd99, 32'd77);
        extra = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (c == 10) flush = 1'b1;
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checkOutput("flush.busyBefore", {31'b0, busy}, 32'd1);
        applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(negedge clk);
        if (done === 1'b1) extra++;
        checkOutput("flush.noDone", 32'(extra), 32'd0);
        checkOutput("flush.busyAfter", {31'b0, busy}, 32'd0);
        checkOutput("flush.stallT", {31'b0, stall}, 32'd1);
        waitDone("flush.restart", 32'hFFFFFFFE, 33, 1'b1);

        // Reset in cycle T+5 of an operation.
        applyStimulus(3'd0, 32'd3, 32'd3);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midReset.stallDuring", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midReset.result", result, 32'd0);
        checkOutput("midReset.done", {31'b0, done}, 32'd0);
        checkOutput("midReset.busy", {31'b0, busy}, 32'd0);
        checkOutput("midReset.stall", {31'b0, stall}, 32'd0);
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checkOutput("midReset.noDone", 32'(extra), 32'd0);

        // Random operations, biased toward divide corner cases.
        for (int i = 0; i < 32; i++) begin
            f   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            else if (sel == 2) b = $urandom_range(1, 15);
            else if (sel == 3) a = $urandom_range(0, 1000);
            runOp($sformatf("rand%0d.f%0d", i, f), f, a, b, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
